// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 timing constants (also used by the VGA generator side),
//   counter width, lock state encoding and a saturating increment helper.
//   No ports; import with "import vga_timing_pkg::*;".
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_H_DAT_BEGIN = 143;
  localparam int VGA_H_DAT_END   = 783;
  localparam int VGA_V_DAT_BEGIN = 34;
  localparam int VGA_V_DAT_END   = 514;
  localparam int VGA_LOCK_FRAMES = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    CHECK,
    LOCKED
  } lock_state_t;

  // Counters and measurements stick at the top value instead of wrapping,
  // so a lost sync shows up as a pinned 1023 rather than a bogus small count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vga_sync_sampler.sv
// vga_sync_sampler
//   Registers the active-low hsync/vsync inputs once per pixel strobe and
//   reports their falling edges for the current sample.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   pix_en        pixel strobe; registers only move when high
//   hsync, vsync  raw active-low sync inputs
//   hs_fall       hsync falls on this pixel (already qualified by pix_en)
//   vs_fall       vsync falls on this pixel (already qualified by pix_en)
module vga_sync_sampler (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  input  logic hsync,
  input  logic vsync,
  output logic hs_fall,
  output logic vs_fall
);

  logic hs_q;
  logic vs_q;

  // Previous-sample history resets to the idle (high) level so a sync that is
  // already low when reset is released still registers as a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else if (pix_en) begin
      hs_q <= hsync;
      vs_q <= vsync;
    end
  end

  assign hs_fall = pix_en & hs_q & ~hsync;
  assign vs_fall = pix_en & vs_q & ~vsync;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive side of a VGA link: recovers line/frame timing from hsync/vsync,
//   measures line length and frame height, runs a lock FSM and emits
//   active-area pixels with x/y coordinates once locked.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   pix_en        pixel strobe; all state advances only when high
//   hsync, vsync  active-low syncs
//   rgb [2:0]     pixel colour
//   pix_valid     x/y/pix_rgb carry an active pixel (only while locked)
//   pix_rgb [2:0] captured colour
//   x, y [9:0]    active-area column / row
//   frame_start   one-clock pulse with the x=0,y=0 pixel
//   locked        timing lock status
//   line_len      last measured line length in pixels
//   frame_lines   last measured frame length in lines
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int H_DAT_BEGIN = VGA_H_DAT_BEGIN,
  parameter int H_DAT_END   = VGA_H_DAT_END,
  parameter int V_DAT_BEGIN = VGA_V_DAT_BEGIN,
  parameter int V_DAT_END   = VGA_V_DAT_END,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [2:0]       rgb,
  output logic             pix_valid,
  output logic [2:0]       pix_rgb,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start,
  output logic             locked,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines
);

  localparam logic [CNT_W-1:0] H_TOTAL_C = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_TOTAL_C = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_BEGIN_C = CNT_W'(H_DAT_BEGIN);
  localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_DAT_END);
  localparam logic [CNT_W-1:0] V_BEGIN_C = CNT_W'(V_DAT_BEGIN);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_DAT_END);
  localparam logic [2:0]       LOCK_C    = 3'(LOCK_FRAMES);

  logic             hs_fall;
  logic             vs_fall;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             vs_pend;
  logic             line_err;
  logic [2:0]       good_cnt;
  lock_state_t      state;

  logic             pending;
  logic [CNT_W-1:0] h_meas;
  logic [CNT_W-1:0] v_meas;
  logic [CNT_W-1:0] p;
  logic [CNT_W-1:0] l;
  logic             frame_bnd;
  logic             line_bad;
  logic             frame_ok;

  lock_state_t      state_next;
  logic [2:0]       good_next;
  logic             locked_next;
  logic             pv_next;
  logic             fs_next;

  vga_sync_sampler u_sampler (
    .clk     (clk),
    .rst     (rst),
    .pix_en  (pix_en),
    .hsync   (hsync),
    .vsync   (vsync),
    .hs_fall (hs_fall),
    .vs_fall (vs_fall)
  );

  // Position of the current sample. A vsync edge arriving on the same sample
  // as the hsync edge already counts as pending, so the line that starts here
  // is line 0 of the new frame.
  always_comb begin
    pending   = vs_pend | vs_fall;
    h_meas    = sat_inc(h_cnt);
    v_meas    = sat_inc(v_cnt);
    p         = hs_fall ? '0 : h_meas;
    l         = v_cnt;
    if (hs_fall) begin
      l = pending ? '0 : v_meas;
    end
    frame_bnd = hs_fall & pending;
    line_bad  = hs_fall & (h_meas != H_TOTAL_C);
    frame_ok  = (v_meas == V_TOTAL_C) && !line_err && !line_bad;
  end

  // Lock FSM next state. Losing hsync (h_cnt pinned at 1023) overrides
  // everything and restarts the search from scratch.
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    if (pix_en) begin
      case (state)
        SEARCH: begin
          if (hs_fall) begin
            state_next = ALIGN;
          end
        end
        ALIGN: begin
          if (frame_bnd) begin
            state_next = CHECK;
            good_next  = '0;
          end
        end
        CHECK: begin
          if (frame_bnd) begin
            if (frame_ok) begin
              good_next = good_cnt + 3'd1;
              if (good_cnt + 3'd1 == LOCK_C) begin
                state_next = LOCKED;
              end
            end else begin
              good_next = '0;
            end
          end
        end
        LOCKED: begin
          if (line_bad || (frame_bnd && !frame_ok)) begin
            state_next = CHECK;
            good_next  = '0;
          end
        end
        default: begin
          state_next = SEARCH;
          good_next  = '0;
        end
      endcase
      if (p == CNT_MAX) begin
        state_next = SEARCH;
        good_next  = '0;
      end
    end
  end

  // Output decisions use the post-update lock state so locked and pixel
  // output change on the same edge that decides them.
  always_comb begin
    locked_next = (state_next == LOCKED);
    pv_next     = locked_next &&
                  (p >= H_BEGIN_C) && (p < H_END_C) &&
                  (l >= V_BEGIN_C) && (l < V_END_C);
    fs_next     = pv_next && (p == H_BEGIN_C) && (l == V_BEGIN_C);
  end

  // Counters, measurements and FSM registers. The first hs_fall out of
  // SEARCH closes a partial line, so it is not stored as a measurement, and
  // frame height is only trusted once a full frame has been seen in CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      vs_pend     <= 1'b0;
      line_err    <= 1'b0;
      good_cnt    <= '0;
      state       <= SEARCH;
      line_len    <= '0;
      frame_lines <= '0;
    end else if (pix_en) begin
      h_cnt    <= p;
      state    <= state_next;
      good_cnt <= good_next;
      if (hs_fall) begin
        v_cnt   <= l;
        vs_pend <= 1'b0;
        if (state != SEARCH) begin
          line_len <= h_meas;
        end
      end else if (vs_fall) begin
        vs_pend <= 1'b1;
      end
      if (frame_bnd) begin
        line_err <= 1'b0;
        if (state == CHECK || state == LOCKED) begin
          frame_lines <= v_meas;
        end
      end else if (line_bad) begin
        line_err <= 1'b1;
      end
    end
  end

  // Registered output stage. Strobes drop on idle clocks; coordinates and
  // colour hold their last active value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked      <= 1'b0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      x           <= '0;
      y           <= '0;
      pix_rgb     <= '0;
    end else if (pix_en) begin
      locked      <= locked_next;
      pix_valid   <= pv_next;
      frame_start <= fs_next;
      if (pv_next) begin
        x       <= p - H_BEGIN_C;
        y       <= l - V_BEGIN_C;
        pix_rgb <= rgb;
      end
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
